vga_fb_reader: RTL and testbench

//  Read side of the RGB frame buffer. The camera/NN write path fills a 320x240 buffer
//  (17-bit address, one pixel per word). This block generates 640x480@60 VGA timing
//  and scans the buffer with 2x pixel/line doubling. It delays hsync/vsync/de so they

---
 rtl/vga_fb_reader.sv | 123 ++++++++++++
 tb/tb_vga_fb_reader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_reader.sv
// rtl/vga_fb_reader.sv - VGA timing generator and 2x-scaled frame buffer scanner
// Sync/de/first are delayed to match the BRAM read latency so rgb_o lines up with them.
module vga_fb_reader #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int RD_LATENCY = 2,
   parameter int PIX_W      = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic             rd_en_o,
   output logic [16:0]      rd_addr_o,
   input  logic [PIX_W-1:0] rd_data_i,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             de_o,
   output logic [PIX_W-1:0] rgb_o,
   output logic             frame_start_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int ROW_W   = H_ACTIVE / 2;
   localparam int HS_LO   = H_ACTIVE + H_FP;
   localparam int HS_HI   = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS_LO   = V_ACTIVE + V_FP;
   localparam int VS_HI   = V_ACTIVE + V_FP + V_SYNC;

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic [16:0]   row_base;
   logic          h_last;
   logic          v_last;
   logic          active;
   logic          hs_raw;
   logic          vs_raw;
   logic          first;
   logic [16:0]   addr;

   // Index 0 is the stage-1 register; index RD_LATENCY feeds the output register.
   logic [RD_LATENCY:0] hs_line;
   logic [RD_LATENCY:0] vs_line;
   logic [RD_LATENCY:0] de_line;
   logic [RD_LATENCY:0] first_line;

   always_comb begin
      h_last = (int'(h_cnt) == H_TOTAL - 1);
      v_last = (int'(v_cnt) == V_TOTAL - 1);
      active = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
      hs_raw = !((int'(h_cnt) >= HS_LO) && (int'(h_cnt) < HS_HI));
      vs_raw = !((int'(v_cnt) >= VS_LO) && (int'(v_cnt) < VS_HI));
      first  = (h_cnt == '0) && (v_cnt == '0);
      addr   = row_base + 17'(h_cnt >> 1);
   end

   // Row base advances after each odd visible line, giving 2x line doubling without a multiplier.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt    <= '0;
         v_cnt    <= '0;
         row_base <= '0;
      end else if (en) begin
         h_cnt <= h_last ? '0 : h_cnt + 1'b1;
         if (h_last) begin
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            if (v_last)
               row_base <= '0;
            else if ((int'(v_cnt) < V_ACTIVE) && v_cnt[0])
               row_base <= row_base + 17'(ROW_W);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_en_o    <= 1'b0;
         rd_addr_o  <= '0;
         hs_line    <= '1;
         vs_line    <= '1;
         de_line    <= '0;
         first_line <= '0;
      end else if (en) begin
         rd_en_o       <= active;
         rd_addr_o     <= active ? addr : 17'd0;
         hs_line[0]    <= hs_raw;
         vs_line[0]    <= vs_raw;
         de_line[0]    <= active;
         first_line[0] <= first;
         for (int i = 1; i <= RD_LATENCY; i++) begin
            hs_line[i]    <= hs_line[i-1];
            vs_line[i]    <= vs_line[i-1];
            de_line[i]    <= de_line[i-1];
            first_line[i] <= first_line[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hsync_o       <= 1'b1;
         vsync_o       <= 1'b1;
         de_o          <= 1'b0;
         rgb_o         <= '0;
         frame_start_o <= 1'b0;
      end else if (en) begin
         hsync_o       <= hs_line[RD_LATENCY];
         vsync_o       <= vs_line[RD_LATENCY];
         de_o          <= de_line[RD_LATENCY];
         rgb_o         <= de_line[RD_LATENCY] ? rd_data_i : '0;
         frame_start_o <= first_line[RD_LATENCY];
      end
   end

endmodule

// File: tb/tb_vga_fb_reader.sv
// tb/tb_vga_fb_reader.sv - scoreboard bench for vga_fb_reader on a reduced raster
module tb_vga_fb_reader;

   localparam int H_ACTIVE = 32, H_FP = 4, H_SYNC = 6, H_BP = 6;
   localparam int V_ACTIVE = 12, V_FP = 2, V_SYNC = 2, V_BP = 3;
   localparam int LAT = 2;
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int FRAME = H_TOTAL * V_TOTAL;
   localparam int ROW = H_ACTIVE / 2;
   localparam int MAX_ADDR = (V_ACTIVE / 2) * ROW - 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        rd_en_o;
   logic [16:0] rd_addr_o;
   logic [11:0] rd_data_i;
   logic        hsync_o, vsync_o, de_o, frame_start_o;
   logic [11:0] rgb_o;
   logic [11:0] bq1 = '0;
   logic [11:0] bq2 = '0;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic [11:0] rgb;
      logic        first;
   } out_t;
   typedef struct packed {
      logic        rd_en;
      logic [16:0] addr;
   } s1_t;

   out_t exp_q[$];
   s1_t  s1_q[$];
   int   checks = 0;
   int   errors = 0;
   int   mh = 0;
   int   mv = 0;
   logic s_en, s_rst;
   out_t o_exp;
   s1_t  s_exp;
   wire [33:0] obs = {rd_en_o, rd_addr_o, hsync_o, vsync_o, de_o, rgb_o, frame_start_o};

   vga_fb_reader #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .RD_LATENCY(LAT), .PIX_W(12)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
      .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
      .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o), .rgb_o(rgb_o),
      .frame_start_o(frame_start_o)
   );

   always #5 clk = ~clk;

   // BRAM model: two en-gated stages, data = address[11:0]
   always @(posedge clk) if (en) begin
      bq1 <= rd_addr_o[11:0];
      bq2 <= bq1;
   end
   assign rd_data_i = bq2;

   function automatic out_t model_out();
      out_t o;
      logic act;
      act     = (mh < H_ACTIVE) && (mv < V_ACTIVE);
      o.hs    = !((mh >= H_ACTIVE + H_FP) && (mh < H_ACTIVE + H_FP + H_SYNC));
      o.vs    = !((mv >= V_ACTIVE + V_FP) && (mv < V_ACTIVE + V_FP + V_SYNC));
      o.de    = act;
      o.rgb   = act ? 12'((mv / 2) * ROW + mh / 2) : 12'd0;
      o.first = (mh == 0) && (mv == 0);
      return o;
   endfunction

   function automatic s1_t model_s1();
      s1_t s;
      logic act;
      act     = (mh < H_ACTIVE) && (mv < V_ACTIVE);
      s.rd_en = act;
      s.addr  = act ? 17'((mv / 2) * ROW + mh / 2) : 17'd0;
      return s;
   endfunction

   task automatic tick(input logic e);
      en = e;
      if (e) begin
         exp_q.push_back(model_out());
         s1_q.push_back(model_s1());
      end
      @(posedge clk);
      if (e) begin
         mh = mh + 1;
         if (mh == H_TOTAL) begin
            mh = 0;
            mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
         end
      end
      #2;
   endtask

   task automatic do_reset(input logic e);
      rst = 1'b1;
      en  = e;
      @(posedge clk);
      #2;
      rst = 1'b0;
      exp_q.delete();
      s1_q.delete();
      for (int i = 0; i < LAT + 1; i++)
         exp_q.push_back('{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 12'd0, first: 1'b0});
      mh = 0;
      mv = 0;
   endtask

   // Scoreboard monitor: every en-tick pops one expected output and one expected read request
   always @(posedge clk) begin
      s_en  = en;
      s_rst = rst;
      #1;
      if (s_en && !s_rst) begin
         checks++;
         if (exp_q.size() == 0 || s1_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
         end else begin
            o_exp = exp_q.pop_front();
            s_exp = s1_q.pop_front();
            if ({hsync_o, vsync_o, de_o, rgb_o, frame_start_o} !== o_exp) begin
               errors++;
               $display("FAIL outputs at %0t: hs/vs/de/rgb/fs got %b %b %b %h %b want %b %b %b %h %b",
                        $time, hsync_o, vsync_o, de_o, rgb_o, frame_start_o,
                        o_exp.hs, o_exp.vs, o_exp.de, o_exp.rgb, o_exp.first);
            end
            checks++;
            if ({rd_en_o, rd_addr_o} !== s_exp) begin
               errors++;
               $display("FAIL read_req at %0t: rd_en/addr got %b %0d want %b %0d",
                        $time, rd_en_o, rd_addr_o, s_exp.rd_en, s_exp.addr);
            end
         end
      end
   end

   task automatic test_reset();
      do_reset(1'b1);
      checks++; if (rd_en_o !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", rd_en_o); end
      checks++; if (rd_addr_o !== 17'd0) begin errors++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr_o); end
      checks++; if (hsync_o !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b want 1", hsync_o); end
      checks++; if (vsync_o !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b want 1", vsync_o); end
      checks++; if (de_o !== 1'b0) begin errors++; $display("FAIL reset_de got %b want 0", de_o); end
      checks++; if (rgb_o !== 12'd0) begin errors++; $display("FAIL reset_rgb got %h want 0", rgb_o); end
      checks++; if (frame_start_o !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", frame_start_o); end
      tick(1'b1);
      checks++;
      if (rd_en_o !== 1'b1 || rd_addr_o !== 17'd0) begin
         errors++; $display("FAIL tick1_read got %b %0d want 1 0", rd_en_o, rd_addr_o);
      end
      tick(1'b1);
      tick(1'b1);
      checks++; if (de_o !== 1'b0) begin errors++; $display("FAIL tick3_de got %b want 0", de_o); end
      tick(1'b1);
      checks++;
      if (de_o !== 1'b1 || rgb_o !== 12'd0 || frame_start_o !== 1'b1) begin
         errors++; $display("FAIL tick4_first got de %b rgb %h fs %b want 1 000 1", de_o, rgb_o, frame_start_o);
      end
   endtask

   task automatic test_frame_stats();
      int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0, max_addr = 0;
      int last_fs = -1, hs_first = -1, w0, w1;
      w0 = LAT + 2;
      w1 = LAT + 2 + 3 * FRAME - 1;
      do_reset(1'b1);
      for (int n = 1; n <= w1; n++) begin
         tick(1'b1);
         if (int'(rd_addr_o) > max_addr) max_addr = int'(rd_addr_o);
         if (n >= w0) begin
            if (de_o === 1'b1) de_cnt++;
            if (hsync_o === 1'b0) begin
               hs_cnt++;
               if (hs_first < 0) hs_first = n - w0;
            end
            if (vsync_o === 1'b0) vs_cnt++;
            if (frame_start_o === 1'b1) begin
               fs_cnt++;
               if (last_fs >= 0) begin
                  checks++;
                  if (n - last_fs != FRAME) begin
                     errors++; $display("FAIL frame_period got %0d want %0d", n - last_fs, FRAME);
                  end
               end
               last_fs = n;
            end
         end
      end
      checks++; if (de_cnt != 3 * H_ACTIVE * V_ACTIVE) begin errors++; $display("FAIL de_count got %0d want %0d", de_cnt, 3 * H_ACTIVE * V_ACTIVE); end
      checks++; if (hs_cnt != 3 * H_SYNC * V_TOTAL) begin errors++; $display("FAIL hsync_low got %0d want %0d", hs_cnt, 3 * H_SYNC * V_TOTAL); end
      checks++; if (hs_first != H_ACTIVE + H_FP) begin errors++; $display("FAIL hsync_start got %0d want %0d", hs_first, H_ACTIVE + H_FP); end
      checks++; if (vs_cnt != 3 * V_SYNC * H_TOTAL) begin errors++; $display("FAIL vsync_low got %0d want %0d", vs_cnt, 3 * V_SYNC * H_TOTAL); end
      checks++; if (fs_cnt != 3) begin errors++; $display("FAIL frame_starts got %0d want 3", fs_cnt); end
      checks++; if (max_addr != MAX_ADDR) begin errors++; $display("FAIL max_addr got %0d want %0d", max_addr, MAX_ADDR); end
   endtask

   task automatic test_en_toggle();
      logic [33:0] prev;
      for (int i = 0; i < FRAME + 100; i++) begin
         tick(1'b1);
         prev = obs;
         tick(1'b0);
         checks++;
         if (obs !== prev) begin
            errors++; $display("FAIL toggle_hold got %h want %h", obs, prev);
         end
      end
   endtask

   task automatic test_en_hold();
      logic [33:0] prev;
      while (!(mh == 10 && mv == 3)) tick(1'b1);
      prev = obs;
      for (int i = 0; i < 50; i++) begin
         tick(1'b0);
         checks++;
         if (obs !== prev) begin
            errors++; $display("FAIL freeze clk %0d got %h want %h", i, obs, prev);
         end
      end
      for (int i = 0; i < 20; i++) tick(1'b1);
   endtask

   task automatic test_mid_reset();
      int guard = 0, n = 0;
      while (!(mh == 20 && mv == 5) && guard < 2 * FRAME) begin
         tick(1'b1);
         guard++;
      end
      checks++;
      if (guard >= 2 * FRAME) begin errors++; $display("FAIL reach_h20_v5 got timeout want position"); end
      do_reset(1'b0);
      checks++;
      if (obs !== {1'b0, 17'd0, 1'b1, 1'b1, 1'b0, 12'd0, 1'b0}) begin
         errors++; $display("FAIL midreset_values got %h want %h", obs, {1'b0, 17'd0, 1'b1, 1'b1, 1'b0, 12'd0, 1'b0});
      end
      while (frame_start_o !== 1'b1 && n < 10) begin
         tick(1'b1);
         n++;
      end
      checks++; if (n != LAT + 2) begin errors++; $display("FAIL fs_after_reset got %0d ticks want %0d", n, LAT + 2); end
      checks++; if (rgb_o !== 12'd0 || de_o !== 1'b1) begin errors++; $display("FAIL fs_pixel got de %b rgb %h want 1 000", de_o, rgb_o); end
      for (int i = 0; i < 3 * H_TOTAL; i++) tick(1'b1);
   endtask

   initial begin
      test_reset();
      test_frame_stats();
      test_en_toggle();
      test_en_hold();
      test_mid_reset();
      tick(1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
